// File: rtl/ls_usb_rx_ctrl.sv
// Low-speed USB receive packet controller.
// Sits behind the bit-level receiver: validates SYNC and PID, decodes tokens,
// streams DATA payload (holding back the trailing CRC16), checks CRC5/CRC16
// and length, and reports a per-packet status strobe at end of packet.
module ls_usb_rx_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       eop,
  input  logic [7:0] rdata,
  input  logic       rdata_ready,
  input  logic [3:0] rbyte_cnt,
  input  logic [6:0] dev_addr,
  output logic [3:0] pid,
  output logic [1:0] pkt_kind,
  output logic [3:0] tok_ep,
  output logic       tok_match,
  output logic [7:0] pl_data,
  output logic       pl_valid,
  output logic [3:0] pl_len,
  output logic       pkt_done,
  output logic       pkt_ok,
  output logic [3:0] err
);

  localparam logic [7:0]  SYNC_BYTE = 8'h80;
  localparam logic [4:0]  CRC5_RES  = 5'b01100;
  localparam logic [15:0] CRC16_RES = 16'h800D;
  localparam logic [3:0]  MAX_DATA  = 4'd10;   // payload 8 + CRC16 2

  // err bit positions: {len, crc, pid, sync}
  localparam logic [3:0] E_SYNC = 4'b0001;
  localparam logic [3:0] E_PID  = 4'b0010;
  localparam logic [3:0] E_CRC  = 4'b0100;
  localparam logic [3:0] E_LEN  = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE, S_PID, S_TOKEN1, S_TOKEN2, S_DATA, S_HSK, S_DISCARD
  } state_t;

  state_t      state_q;
  logic [3:0]  pid_q;
  logic [1:0]  kind_q;
  logic [3:0]  tok_ep_q;
  logic        tok_match_q;
  logic [7:0]  pl_data_q;
  logic        pl_valid_q;
  logic [3:0]  pl_len_q;
  logic        done_q;
  logic        ok_q;
  logic [3:0]  err_q;
  logic        eop_q;       // eop delayed, for rising-edge detection
  logic        eop_pend_q;  // eop rose together with a byte; finish next cycle
  logic        supp_q;      // packet joined mid-stream, no status report
  logic [3:0]  cnt_q;       // bytes received after the PID
  logic [7:0]  hold0_q;     // newest byte of the CRC holding pipe
  logic [7:0]  hold1_q;     // oldest byte of the CRC holding pipe
  logic [4:0]  crc5_q;
  logic [15:0] crc16_q;
  logic [7:0]  tok_b1_q;

  logic        eop_rise;
  logic        eop_fire;
  logic [3:0]  err_base_d;
  logic [3:0]  len_base_d;
  logic [3:0]  eop_err_d;
  logic [3:0]  fin_err_d;
  logic [4:0]  crc5_d;
  logic [15:0] crc16_d;

  // CRC5, poly x^5+x^2+1, one byte shifted in LSB first.
  function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] d);
    logic [4:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (d[i] ^ r[4]) r = {r[3:0], 1'b0} ^ 5'h05;
      else             r = {r[3:0], 1'b0};
    end
    return r;
  endfunction

  // CRC16, poly 0x8005, one byte shifted in LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (d[i] ^ r[15]) r = {r[14:0], 1'b0} ^ 16'h8005;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  // A byte arriving with the eop edge is handled first; completion is deferred.
  assign eop_rise   = eop && !eop_q;
  assign eop_fire   = eop_pend_q || (eop_rise && !rdata_ready);
  // Status of the previous packet clears the cycle after its done strobe.
  assign err_base_d = done_q ? 4'd0 : err_q;
  assign len_base_d = done_q ? 4'd0 : pl_len_q;
  assign crc5_d     = crc5_byte(crc5_q, rdata);
  assign crc16_d    = crc16_byte(crc16_q, rdata);
  assign fin_err_d  = err_base_d | eop_err_d;

  // Errors that only become known when the packet ends.
  always_comb begin
    eop_err_d = 4'd0;
    case (state_q)
      S_PID, S_TOKEN1: eop_err_d = E_LEN;
      S_TOKEN2:        if (cnt_q < 4'd2) eop_err_d = E_LEN;
      S_DATA: begin
        if (cnt_q < 4'd2)              eop_err_d = E_LEN;
        else if (crc16_q != CRC16_RES) eop_err_d = E_CRC;
      end
      default: eop_err_d = 4'd0;
    endcase
  end

  // Packet FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pid_q       <= 4'd0;
      kind_q      <= 2'd0;
      tok_ep_q    <= 4'd0;
      tok_match_q <= 1'b0;
      pl_data_q   <= 8'd0;
      pl_valid_q  <= 1'b0;
      pl_len_q    <= 4'd0;
      done_q      <= 1'b0;
      ok_q        <= 1'b0;
      err_q       <= 4'd0;
      eop_q       <= 1'b0;
      eop_pend_q  <= 1'b0;
      supp_q      <= 1'b0;
      cnt_q       <= 4'd0;
      hold0_q     <= 8'd0;
      hold1_q     <= 8'd0;
      crc5_q      <= 5'd0;
      crc16_q     <= 16'd0;
      tok_b1_q    <= 8'd0;
    end else begin
      eop_q      <= eop;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      pl_valid_q <= 1'b0;
      err_q      <= err_base_d;
      pl_len_q   <= len_base_d;
      if (eop_fire) begin
        eop_pend_q <= 1'b0;
        if (state_q != S_IDLE && !supp_q) begin
          done_q <= 1'b1;
          err_q  <= fin_err_d;
          ok_q   <= (fin_err_d == 4'd0) && (kind_q != 2'd3);
        end
        state_q <= S_IDLE;
        supp_q  <= 1'b0;
      end else begin
        if (eop_rise && rdata_ready) eop_pend_q <= 1'b1;
        if (rdata_ready) begin
          case (state_q)
            S_IDLE: begin
              if (rbyte_cnt != 4'd0) begin
                supp_q  <= 1'b1;
                state_q <= S_DISCARD;
              end else if (rdata == SYNC_BYTE) begin
                state_q <= S_PID;
              end else begin
                err_q   <= err_base_d | E_SYNC;
                state_q <= S_DISCARD;
              end
            end
            S_PID: begin
              cnt_q <= 4'd0;
              if (rdata[7:4] != ~rdata[3:0]) begin
                err_q   <= err_base_d | E_PID;
                kind_q  <= 2'd3;
                state_q <= S_DISCARD;
              end else begin
                pid_q <= rdata[3:0];
                case (rdata[1:0])
                  2'b01: begin kind_q <= 2'd0; state_q <= S_TOKEN1; end
                  2'b11: begin kind_q <= 2'd1; state_q <= S_DATA; crc16_q <= 16'hFFFF; end
                  2'b10: begin kind_q <= 2'd2; state_q <= S_HSK; end
                  default: begin kind_q <= 2'd3; state_q <= S_DISCARD; end
                endcase
              end
            end
            S_TOKEN1: begin
              tok_b1_q <= rdata;
              crc5_q   <= crc5_byte(5'h1F, rdata);
              cnt_q    <= 4'd1;
              state_q  <= S_TOKEN2;
            end
            S_TOKEN2: begin
              if (cnt_q == 4'd1) begin
                cnt_q       <= 4'd2;
                tok_ep_q    <= {rdata[2:0], tok_b1_q[7]};
                tok_match_q <= (tok_b1_q[6:0] == dev_addr);
                if (crc5_d != CRC5_RES) err_q <= err_base_d | E_CRC;
              end else begin
                err_q   <= err_base_d | E_LEN;
                state_q <= S_DISCARD;
              end
            end
            S_DATA: begin
              if (cnt_q == MAX_DATA) begin
                err_q   <= err_base_d | E_LEN;
                state_q <= S_DISCARD;
              end else begin
                cnt_q   <= cnt_q + 4'd1;
                crc16_q <= crc16_d;
                hold1_q <= hold0_q;
                hold0_q <= rdata;
                // Pipe already holds two bytes: the oldest is payload, not CRC.
                if (cnt_q >= 4'd2) begin
                  pl_data_q  <= hold1_q;
                  pl_valid_q <= 1'b1;
                  pl_len_q   <= len_base_d + 4'd1;
                end
              end
            end
            S_HSK: begin
              err_q   <= err_base_d | E_LEN;
              state_q <= S_DISCARD;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign pid       = pid_q;
  assign pkt_kind  = kind_q;
  assign tok_ep    = tok_ep_q;
  assign tok_match = tok_match_q;
  assign pl_data   = pl_data_q;
  assign pl_valid  = pl_valid_q;
  assign pl_len    = pl_len_q;
  assign pkt_done  = done_q;
  assign pkt_ok    = ok_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ls_usb_rx_ctrl.sv
// Self-checking bench for ls_usb_rx_ctrl: directed packets plus randomized
// packets compared against a packet-level reference model.
module tb_ls_usb_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       eop = 1'b0;
  logic [7:0] rdata = 8'd0;
  logic       rdata_ready = 1'b0;
  logic [3:0] rbyte_cnt = 4'd0;
  logic [6:0] dev_addr = 7'd0;
  logic [3:0] pid;
  logic [1:0] pkt_kind;
  logic [3:0] tok_ep;
  logic       tok_match;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic [3:0] pl_len;
  logic       pkt_done;
  logic       pkt_ok;
  logic [3:0] err;

  always #5 clk = ~clk;

  ls_usb_rx_ctrl dut (
    .clk(clk), .rst_n(rst_n), .eop(eop), .rdata(rdata),
    .rdata_ready(rdata_ready), .rbyte_cnt(rbyte_cnt), .dev_addr(dev_addr),
    .pid(pid), .pkt_kind(pkt_kind), .tok_ep(tok_ep), .tok_match(tok_match),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_len(pl_len),
    .pkt_done(pkt_done), .pkt_ok(pkt_ok), .err(err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- output monitor ----------------
  int         done_cnt = 0;
  int         post_cnt = 0;
  logic [7:0] pl_hist[$];
  logic       prev_done = 1'b0;
  logic       c_ok = 1'b0;
  logic [3:0] c_err = 4'd0;
  logic [3:0] c_len = 4'd0;
  logic [3:0] post_err = 4'd0;
  logic [3:0] post_len = 4'd0;

  always @(negedge clk) begin
    if (pl_valid) pl_hist.push_back(pl_data);
    if (prev_done) begin
      post_err <= err;
      post_len <= pl_len;
      post_cnt <= post_cnt + 1;
    end
    if (pkt_done) begin
      done_cnt <= done_cnt + 1;
      c_ok     <= pkt_ok;
      c_err    <= err;
      c_len    <= pl_len;
    end
    prev_done <= pkt_done;
  end

  // ---------------- packet construction ----------------
  logic [7:0] pkt[$];

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  function automatic logic [4:0] crc5_bits(input logic [15:0] bits, input int nb);
    logic [4:0] c;
    logic fb;
    c = 5'h1F;
    for (int i = 0; i < nb; i++) begin
      fb = bits[i] ^ c[4];
      c = {c[3:0], 1'b0};
      if (fb) c = c ^ 5'h05;
    end
    return c;
  endfunction

  // CRC16 over pkt[a..end], bytes LSB first.
  function automatic logic [15:0] crc16_from(input int a);
    logic [15:0] c;
    logic [7:0] b;
    logic fb;
    c = 16'hFFFF;
    for (int k = a; k < pkt.size(); k++) begin
      b = pkt[k];
      for (int i = 0; i < 8; i++) begin
        fb = b[i] ^ c[15];
        c = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    end
    return c;
  endfunction

  task automatic build_token(input logic [7:0] p, input logic [6:0] addr, input logic [3:0] ep);
    logic [4:0] c;
    c = crc5_bits({5'd0, ep, addr}, 11);
    pkt.delete();
    pkt.push_back(8'h80);
    pkt.push_back(p);
    pkt.push_back({ep[0], addr});
    pkt.push_back({~c[0], ~c[1], ~c[2], ~c[3], ~c[4], ep[3:1]});
  endtask

  task automatic build_data(input logic [7:0] p, input int npay);
    logic [15:0] c;
    pkt.delete();
    pkt.push_back(8'h80);
    pkt.push_back(p);
    for (int i = 0; i < npay; i++) pkt.push_back(8'($urandom_range(0, 255)));
    c = crc16_from(2);
    pkt.push_back(rev8(~c[15:8]));
    pkt.push_back(rev8(~c[7:0]));
  endtask

  // ---------------- reference model ----------------
  logic [3:0] m_pid = 4'd0;
  logic [1:0] m_kind = 2'd0;
  logic [3:0] m_tep = 4'd0;
  logic       m_tm = 1'b0;
  int         e_done;
  logic [3:0] e_err;
  logic       e_ok;
  logic [7:0] e_pl[$];

  task automatic model(input int start_idx);
    logic [7:0] p, b1, b2;
    int n;
    e_pl.delete();
    e_err = 4'd0;
    e_ok  = 1'b0;
    e_done = 0;
    if (start_idx != 0) return;             // joined mid-packet: silent
    e_done = 1;
    if (pkt[0] != 8'h80) begin e_err = 4'b0001; return; end
    if (pkt.size() < 2) begin e_err = 4'b1000; return; end
    p = pkt[1];
    n = pkt.size() - 2;
    if (p[7:4] != ~p[3:0]) begin
      e_err = 4'b0010;
      m_kind = 2'd3;
    end else begin
      m_pid = p[3:0];
      case (p[1:0])
        2'b01: begin
          m_kind = 2'd0;
          if (n >= 2) begin
            b1 = pkt[2];
            b2 = pkt[3];
            m_tep = {b2[2:0], b1[7]};
            m_tm  = (b1[6:0] == dev_addr);
            if (crc5_bits({b2, b1}, 16) != 5'b01100) e_err |= 4'b0100;
          end
          if (n != 2) e_err |= 4'b1000;
        end
        2'b11: begin
          m_kind = 2'd1;
          if (n > 10) begin
            e_err |= 4'b1000;
            for (int i = 0; i < 8; i++) e_pl.push_back(pkt[2+i]);
          end else if (n < 2) begin
            e_err |= 4'b1000;
          end else begin
            for (int i = 0; i < n - 2; i++) e_pl.push_back(pkt[2+i]);
            if (crc16_from(2) != 16'h800D) e_err |= 4'b0100;
          end
        end
        2'b10: begin
          m_kind = 2'd2;
          if (n > 0) e_err |= 4'b1000;
        end
        default: m_kind = 2'd3;
      endcase
    end
    e_ok = (e_err == 4'd0) && (m_kind != 2'd3);
  endtask

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] b, input int idx, input bit with_eop);
    @(posedge clk); #1;
    rdata = b;
    rbyte_cnt = (idx > 15) ? 4'd15 : 4'(idx);
    rdata_ready = 1'b1;
    if (with_eop) eop = 1'b1;
    @(posedge clk); #1;
    rdata_ready = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  task automatic run_pkt(input int start_idx, input bit ewl, input string tag);
    int d0, p0, q0, ng;
    d0 = done_cnt;
    p0 = pl_hist.size();
    q0 = post_cnt;
    for (int i = 0; i < pkt.size(); i++)
      send_byte(pkt[i], start_idx + i, ewl && (i == pkt.size() - 1));
    if (!ewl) begin @(posedge clk); #1; eop = 1'b1; end
    repeat ($urandom_range(3, 12)) @(posedge clk);
    #1 eop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model(start_idx);
    check({tag, "_done"}, done_cnt - d0, e_done);
    if (e_done != 0) begin
      check({tag, "_ok"}, c_ok, e_ok);
      check({tag, "_err"}, c_err, e_err);
      check({tag, "_len"}, c_len, e_pl.size());
      check({tag, "_postn"}, post_cnt - q0, 1);
      check({tag, "_posterr"}, post_err, 0);
      check({tag, "_postlen"}, post_len, 0);
    end
    check({tag, "_pid"}, pid, m_pid);
    check({tag, "_kind"}, pkt_kind, m_kind);
    check({tag, "_tokep"}, tok_ep, m_tep);
    check({tag, "_tokm"}, tok_match, m_tm);
    ng = pl_hist.size() - p0;
    check({tag, "_plcnt"}, ng, e_pl.size());
    for (int i = 0; i < ng && i < e_pl.size(); i++)
      check($sformatf("%s_pl%0d", tag, i), pl_hist[p0+i], e_pl[i]);
  endtask

  function automatic logic [7:0] pick_pid(input int cls);
    int r;
    r = $urandom_range(0, 3);
    if (cls == 0) return (r == 0) ? 8'hE1 : (r == 1) ? 8'h69 : (r == 2) ? 8'h2D : 8'hA5;
    if (cls == 1) return (r < 2) ? 8'hC3 : 8'h4B;
    return (r == 0) ? 8'hD2 : (r == 1) ? 8'h5A : 8'h1E;
  endfunction

  task automatic gen_rand(output int start_idx);
    int r, k;
    logic [7:0] b;
    logic [3:0] nib;
    logic [6:0] a;
    start_idx = 0;
    r = $urandom_range(0, 99);
    if (r < 30) begin
      a = ($urandom_range(0, 1) == 1) ? dev_addr : 7'($urandom_range(0, 127));
      build_token(pick_pid(0), a, 4'($urandom_range(0, 15)));
      k = $urandom_range(0, 9);
      if (k == 0) void'(pkt.pop_back());
      else if (k == 1) pkt.push_back(8'($urandom_range(0, 255)));
      else if (k < 4) pkt[3] = pkt[3] ^ (8'd1 << $urandom_range(0, 7));
    end else if (r < 60) begin
      build_data(pick_pid(1), $urandom_range(0, 9));
      k = $urandom_range(0, 9);
      if (k < 2) begin
        b = 8'd1 << $urandom_range(0, 7);
        pkt[$urandom_range(2, pkt.size() - 1)] ^= b;
      end else if (k == 2) begin
        while (pkt.size() > 2 + $urandom_range(0, 1)) void'(pkt.pop_back());
      end
    end else if (r < 75) begin
      pkt.delete(); pkt.push_back(8'h80); pkt.push_back(pick_pid(2));
      if ($urandom_range(0, 4) == 0) pkt.push_back(8'($urandom_range(0, 255)));
    end else if (r < 82) begin
      pkt.delete(); pkt.push_back(8'h80);
      b = 8'($urandom_range(0, 255));
      while (b[7:4] == ~b[3:0]) b = 8'($urandom_range(0, 255));
      pkt.push_back(b);
      repeat ($urandom_range(0, 3)) pkt.push_back(8'($urandom_range(0, 255)));
    end else if (r < 86) begin
      nib = {2'($urandom_range(0, 3)), 2'b00};
      pkt.delete(); pkt.push_back(8'h80); pkt.push_back({~nib, nib});
      repeat ($urandom_range(0, 2)) pkt.push_back(8'($urandom_range(0, 255)));
    end else if (r < 92) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'h80) b = 8'h81;
      pkt.delete(); pkt.push_back(b);
      repeat ($urandom_range(1, 3)) pkt.push_back(8'($urandom_range(0, 255)));
    end else begin
      build_data(pick_pid(1), $urandom_range(0, 4));
      void'(pkt.pop_front());
      start_idx = $urandom_range(1, 5);
    end
  endtask

  logic [29:0] all_outs;
  assign all_outs = {pid, pkt_kind, tok_ep, tok_match, pl_data, pl_valid,
                     pl_len, pkt_done, pkt_ok, err};

  logic [7:0] full[$];
  int d0, sidx;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", all_outs, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // eop with nothing received
    d0 = done_cnt;
    @(posedge clk); #1 eop = 1'b1;
    repeat (6) @(posedge clk);
    #1 eop = 1'b0;
    repeat (3) @(posedge clk);
    check("idle_eop_done", done_cnt - d0, 0);

    // ACK handshake
    dev_addr = 7'd5;
    pkt.delete(); pkt.push_back(8'h80); pkt.push_back(8'hD2);
    run_pkt(0, 0, "ack");
    check("ack_pid_c", pid, 4'h2);
    check("ack_kind_c", pkt_kind, 2'd2);
    check("ack_ok_c", c_ok, 1);
    check("ack_err_c", c_err, 0);

    // IN token addr 5 ep 1, matching and non-matching device address
    build_token(8'h69, 7'd5, 4'd1);
    run_pkt(0, 1, "in5");
    check("in5_ep_c", tok_ep, 4'd1);
    check("in5_match_c", tok_match, 1);
    check("in5_ok_c", c_ok, 1);
    dev_addr = 7'd6;
    run_pkt(0, 0, "in6");
    check("in6_match_c", tok_match, 0);
    check("in6_ok_c", c_ok, 1);

    // DATA0 with 3 payload bytes, then a corrupted CRC
    build_data(8'hC3, 0);
    pkt.delete(); pkt.push_back(8'h80); pkt.push_back(8'hC3);
    pkt.push_back(8'h01); pkt.push_back(8'h02); pkt.push_back(8'h03);
    begin
      logic [15:0] c;
      c = crc16_from(2);
      pkt.push_back(rev8(~c[15:8]));
      pkt.push_back(rev8(~c[7:0]));
    end
    run_pkt(0, 0, "d3");
    check("d3_len_c", c_len, 3);
    check("d3_ok_c", c_ok, 1);
    check("d3_last_c", pl_hist[pl_hist.size()-1], 8'h03);
    pkt[pkt.size()-1] = pkt[pkt.size()-1] ^ 8'h10;
    run_pkt(0, 1, "d3bad");
    check("d3bad_err_c", c_err, 4'b0100);
    check("d3bad_ok_c", c_ok, 0);

    // zero-length DATA1
    pkt.delete(); pkt.push_back(8'h80); pkt.push_back(8'h4B);
    pkt.push_back(8'h00); pkt.push_back(8'h00);
    run_pkt(0, 0, "zlp");
    check("zlp_len_c", c_len, 0);
    check("zlp_ok_c", c_ok, 1);

    // bad PID check, bad SYNC
    pkt.delete(); pkt.push_back(8'h80); pkt.push_back(8'h61);
    run_pkt(0, 0, "badpid");
    check("badpid_err_c", c_err, 4'b0010);
    check("badpid_kind_c", pkt_kind, 2'd3);
    pkt.delete(); pkt.push_back(8'h81); pkt.push_back(8'hD2);
    run_pkt(0, 0, "badsync");
    check("badsync_err_c", c_err, 4'b0001);

    // reset in the middle of a DATA packet
    build_data(8'hC3, 3);
    full = pkt;
    for (int i = 0; i < 3; i++) send_byte(full[i], i, 1'b0);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_outs", all_outs, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    m_pid = 4'd0; m_kind = 2'd0; m_tep = 4'd0; m_tm = 1'b0;
    pkt.delete();
    for (int i = 3; i < full.size(); i++) pkt.push_back(full[i]);
    run_pkt(3, 0, "midrst_tail");
    build_data(8'h4B, 2);
    run_pkt(0, 0, "after_rst");
    check("after_rst_ok_c", c_ok, 1);

    // randomized packets
    for (int n = 0; n < 70; n++) begin
      dev_addr = 7'($urandom_range(0, 127));
      gen_rand(sidx);
      run_pkt(sidx, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
